md_unit_ctrl: RTL and testbench
===============================

Name: md_unit_ctrl

Overview:
- Multi-cycle multiply/divide sequencer with the architectural HI/LO registers. Sits in EX beside the ALU.
- Accepts one operation per start pulse, holds busy for a fixed latency, then commits the result to HI/LO.
- Hazard logic stalls any HI/LO consumer while busy is high.
- Also serves MTHI/MTLO writes and aborts an in-flight operation on cancel (exception flush).

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; launches md_op on srca/srcb
- md_op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-ops
- srca  in  32  rs operand (multiplicand or dividend; MTHI/MTLO data)
- srcb  in  32  rt operand (multiplier or divisor)
- cancel  in  1  abort the in-flight operation; HI/LO are not written
- busy  out  1  operation in flight
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (async, rst_n=0): state=IDLE, busy=0, hi=0, lo=0, counter=0, pending regs=0. Release is synchronous to clk.
- FSM has two states: IDLE and RUN.
- IDLE, start=1, cancel=0, op in MULT/MULTU/DIV/DIVU:
  - Result computed combinationally from srca/srcb and captured at that edge into pend_hi/pend_lo.
  - counter loaded with LAT-1, where LAT = MULT_CYCLES or DIV_CYCLES.
  - Next state RUN, busy=1.
- RUN:
  - counter decrements each edge.
  - At the edge where counter==0: hi<=pend_hi, lo<=pend_lo, busy<=0, state<=IDLE.
  - busy is therefore high for exactly LAT cycles after the start edge. New HI/LO values are visible in the cycle busy first reads 0.
- MTHI/MTLO with start in IDLE: hi (or lo) <= srca at that edge. busy stays 0. No state change.
- start while in RUN: ignored, because upstream must stall. The bench flags it as a protocol error, but the DUT keeps running the original operation.
- cancel=1 in RUN: state<=IDLE, busy<=0, HI/LO unchanged, counter cleared. cancel has priority over completion in the same cycle.
- start and cancel in the same IDLE cycle: start is dropped.
- Arithmetic:
  - MULT: {hi,lo} = signed 32x32 -> 64 product.
  - MULTU: {hi,lo} = unsigned 32x32 -> 64 product.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divide by zero (DIV/DIVU, srcb==0): operation runs the full DIV_CYCLES, busy behaves normally, and HI/LO are left unchanged at commit (pending-write enable cleared).
- Reset asserted mid-RUN: immediate return to reset values. The pending result is lost.
- The counter is 4 bits wide. Counter wrap never occurs because completion is checked at 0 before decrement.

Decomposition:
- Shared package md_pkg:
  - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO).
  - Default latency constants.
  - Helper predicate is_md_long(op).
  - The ID-stage decoder reuses these same encodings.
- One sub-module, md_compute: purely combinational, (op, srca, srcb) -> {res_hi, res_lo, res_we}.
  - Contains signed/unsigned multiply, divide, the div-by-zero rule and the overflow rule.
- The FSM, counter, pending regs and HI/LO live in md_unit_ctrl.

Test Plan:
- Reset: with busy mid-run, pulse rst_n low for a half cycle -> busy=0, hi=0, lo=0 immediately, with no clk edge needed.
- MULT timing:
  - Stimulus: MULT srca=0xFFFFFFFE (-2), srcb=3.
  - busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Repeat as MULTU with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV signs:
  - DIV -7/2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000 / -1 -> lo=0x80000000, hi=0.
  - DIVU 7/2 -> lo=3, hi=1.
- Divide by zero: preload hi=0x11, lo=0x22 via MTHI/MTLO, then DIV 5/0 -> busy 10 cycles, hi=0x11, lo=0x22 unchanged.
- Cancel:
  - Start MULT, assert cancel on the 3rd busy cycle -> busy drops next edge, HI/LO keep prior values.
  - Assert cancel on the final busy cycle -> still no commit.
- MTHI/MTLO and protocol: MTHI srca=0xDEADBEEF -> hi updates at that edge, busy never asserts. A start with DIV during a MULT run is ignored, and the MULT result still commits at cycle 5.

Source files
------------

// File: rtl/md_pkg.sv
// Shared encodings and helpers for the multiply/divide unit.
// The ID-stage decoder uses the same md_op encodings.
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'b000;
    localparam logic [2:0] MD_MULTU = 3'b001;
    localparam logic [2:0] MD_DIV   = 3'b010;
    localparam logic [2:0] MD_DIVU  = 3'b011;
    localparam logic [2:0] MD_MTHI  = 3'b100;
    localparam logic [2:0] MD_MTLO  = 3'b101;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Multi-cycle ops (MULT/MULTU/DIV/DIVU) occupy the 000..011 code space.
    function automatic logic is_md_long(input logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface md_unit_ctrl_if;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, srca, srcb, cancel,
        input  busy, hi, lo
    );

    modport slave (
        input  start, md_op, srca, srcb, cancel,
        output busy, hi, lo
    );
endinterface

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath producing the HI/LO result
// for a multi-cycle op, plus the write enable applied at commit.
module md_compute
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        res_we
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] divisor_s;
    logic [31:0] divisor_u;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;

    // Products, divides and the divisor substitutions that keep the
    // dividers free of undefined cases.
    always_comb begin
        prod_s   = 64'($signed({{32{srca[31]}}, srca}) * $signed({{32{srcb[31]}}, srcb}));
        prod_u   = {32'b0, srca} * {32'b0, srcb};
        div_zero = (srcb == 32'd0);
        div_ovf  = (srca == 32'h8000_0000) && (srcb == 32'hFFFF_FFFF);
        // Dividing by 1 yields exactly the required overflow result
        // (quotient 0x80000000, remainder 0); divide-by-zero results are
        // discarded through res_we, so any safe divisor works there.
        divisor_s = (div_zero || div_ovf) ? 32'd1 : srcb;
        divisor_u = div_zero ? 32'd1 : srcb;
        quot_s   = $signed(srca) / $signed(divisor_s);
        rem_s    = $signed(srca) % $signed(divisor_s);
        quot_u   = srca / divisor_u;
        rem_u    = srca % divisor_u;
    end

    // Result select by op; non-multi-cycle codes never commit.
    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        res_we = 1'b0;
        case (op)
            MD_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
            MD_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
            MD_DIV:   begin res_hi = rem_s; res_lo = quot_s; res_we = !div_zero; end
            MD_DIVU:  begin res_hi = rem_u; res_lo = quot_u; res_we = !div_zero; end
            default:  ;
        endcase
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: captures the result at launch, holds busy
// for a fixed latency, then commits to HI/LO unless cancelled.
//
//   state   | meaning
//   --------+--------------------------------------------------
//   ST_IDLE | no op in flight; accepts start, MTHI/MTLO
//   ST_RUN  | op in flight; counter runs down to commit at 0
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic            clk,
    input logic            rst_n,
    md_unit_ctrl_if.slave  bus
);

    localparam logic [3:0] LAT_MULT = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] LAT_DIV  = 4'(DIV_CYCLES - 1);

    md_state_e   state;
    logic [3:0]  cnt;
    logic [31:0] pend_hi;
    logic [31:0] pend_lo;
    logic        pend_we;
    logic        busy_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        res_we;

    md_compute u_compute (
        .op     (bus.md_op),
        .srca   (bus.srca),
        .srcb   (bus.srcb),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .res_we (res_we)
    );

    assign bus.busy = busy_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // Sequencer FSM with latency counter, pending result and HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_we <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start && !bus.cancel) begin
                        if (is_md_long(bus.md_op)) begin
                            pend_hi <= res_hi;
                            pend_lo <= res_lo;
                            pend_we <= res_we;
                            cnt     <= bus.md_op[1] ? LAT_DIV : LAT_MULT;
                            busy_q  <= 1'b1;
                            state   <= ST_RUN;
                        end else if (bus.md_op == MD_MTHI) begin
                            hi_q <= bus.srca;
                        end else if (bus.md_op == MD_MTLO) begin
                            lo_q <= bus.srca;
                        end
                    end
                end
                ST_RUN: begin
                    // Cancel wins over a same-cycle completion.
                    if (bus.cancel) begin
                        cnt    <= 4'd0;
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (cnt == 4'd0) begin
                        if (pend_we) begin
                            hi_q <= pend_hi;
                            lo_q <= pend_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Directed bench for md_unit_ctrl: timing, arithmetic, cancel, MTHI/MTLO.
module tb_md_unit_ctrl;
    import md_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    md_unit_ctrl_if mdif ();

    md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mdif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch one op: drive at negedge, hold across one rising edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdif.start = 1'b1;
        mdif.md_op = op;
        mdif.srca  = a;
        mdif.srcb  = b;
        @(posedge clk);
        #1;
        mdif.start = 1'b0;
    endtask

    // Count negedges with busy high until it drops (bounded).
    task automatic count_busy(input int start_n, output int n);
        n = start_n;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdif.busy === 1'b1) n++;
            else break;
        end
    endtask

    task automatic chk_busy_hilo(input string name, input int n, input int exp_n,
                                 input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        checks++;
        if (n !== exp_n) begin
            failures++;
            $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_n);
        end
        checks++;
        if (mdif.hi !== exp_hi) begin
            failures++;
            $display("FAIL %s hi got=%08h exp=%08h", name, mdif.hi, exp_hi);
        end
        checks++;
        if (mdif.lo !== exp_lo) begin
            failures++;
            $display("FAIL %s lo got=%08h exp=%08h", name, mdif.lo, exp_lo);
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0;
        #12;
        checks++;
        if (mdif.busy !== 1'b0 || mdif.hi !== 32'd0 || mdif.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_init busy=%b hi=%08h lo=%08h exp 0/0/0", mdif.busy, mdif.hi, mdif.lo);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        issue(MD_MULT, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (mdif.busy !== 1'b1) begin
            failures++;
            $display("FAIL reset_prerun busy got=%b exp=1", mdif.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (mdif.busy !== 1'b0 || mdif.hi !== 32'd0 || mdif.lo !== 32'd0) begin
            failures++;
            $display("FAIL reset_async busy=%b hi=%08h lo=%08h exp 0/0/0", mdif.busy, mdif.hi, mdif.lo);
        end
        #2;
        rst_n = 1'b1;
        count_busy(0, n);
        chk_busy_hilo("reset_lost", n, 0, 32'd0, 32'd0);
    endtask

    task automatic test_mult();
        int n;
        issue(MD_MULT, 32'hFFFF_FFFE, 32'd3);
        count_busy(0, n);
        chk_busy_hilo("mult", n, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        issue(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        count_busy(0, n);
        chk_busy_hilo("multu", n, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    endtask

    task automatic test_div();
        int n;
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        count_busy(0, n);
        chk_busy_hilo("div_neg", n, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        count_busy(0, n);
        chk_busy_hilo("div_ovf", n, 10, 32'h0000_0000, 32'h8000_0000);
        issue(MD_DIVU, 32'd7, 32'd2);
        count_busy(0, n);
        chk_busy_hilo("divu", n, 10, 32'd1, 32'd3);
        issue(MD_DIVU, 32'hFFFF_FFF9, 32'd2);
        count_busy(0, n);
        chk_busy_hilo("divu_big", n, 10, 32'd1, 32'h7FFF_FFFC);
    endtask

    task automatic test_div_zero();
        int n;
        issue(MD_MTHI, 32'h11, 32'd0);
        issue(MD_MTLO, 32'h22, 32'd0);
        issue(MD_DIV, 32'd5, 32'd0);
        count_busy(0, n);
        chk_busy_hilo("div_zero", n, 10, 32'h11, 32'h22);
        issue(MD_DIVU, 32'd9, 32'd0);
        count_busy(0, n);
        chk_busy_hilo("divu_zero", n, 10, 32'h11, 32'h22);
    endtask

    task automatic test_cancel();
        int n;
        // Cancel on 3rd busy cycle.
        issue(MD_MULT, 32'd3, 32'd4);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mdif.cancel = 1'b1;
        @(posedge clk);
        #1;
        mdif.cancel = 1'b0;
        count_busy(0, n);
        chk_busy_hilo("cancel_mid", n, 0, 32'h11, 32'h22);
        // Cancel on the final busy cycle, same edge as completion.
        issue(MD_MULT, 32'd3, 32'd4);
        for (int i = 0; i < 5; i++) @(negedge clk);
        checks++;
        if (mdif.busy !== 1'b1) begin
            failures++;
            $display("FAIL cancel_last_pre busy got=%b exp=1", mdif.busy);
        end
        mdif.cancel = 1'b1;
        @(posedge clk);
        #1;
        mdif.cancel = 1'b0;
        count_busy(0, n);
        chk_busy_hilo("cancel_last", n, 0, 32'h11, 32'h22);
        // Start together with cancel in idle is dropped.
        @(negedge clk);
        mdif.cancel = 1'b1;
        issue(MD_MULT, 32'd3, 32'd4);
        mdif.cancel = 1'b0;
        count_busy(0, n);
        chk_busy_hilo("cancel_start", n, 0, 32'h11, 32'h22);
    endtask

    task automatic test_mthi_mtlo();
        int n;
        issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
        checks++;
        if (mdif.hi !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL mthi_edge hi got=%08h exp=deadbeef", mdif.hi);
        end
        count_busy(0, n);
        chk_busy_hilo("mthi", n, 0, 32'hDEAD_BEEF, 32'h22);
        issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
        count_busy(0, n);
        chk_busy_hilo("mtlo", n, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        issue(3'b111, 32'h5555_5555, 32'd1);
        count_busy(0, n);
        chk_busy_hilo("noop", n, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    endtask

    task automatic test_back_to_back();
        int n;
        issue(MD_MULT, 32'd6, 32'd7);
        @(negedge clk);
        @(negedge clk);
        $display("note: protocol violation injected (start while busy), DUT must ignore it");
        mdif.start = 1'b1;
        mdif.md_op = MD_DIV;
        mdif.srca  = 32'd100;
        mdif.srcb  = 32'd3;
        @(posedge clk);
        #1;
        mdif.start = 1'b0;
        count_busy(2, n);
        chk_busy_hilo("start_in_run", n, 5, 32'd0, 32'd42);
        count_busy(0, n);
        chk_busy_hilo("no_relaunch", n, 0, 32'd0, 32'd42);
        // Immediate follow-on op right after commit.
        issue(MD_MULTU, 32'h0001_0000, 32'h0001_0000);
        count_busy(0, n);
        chk_busy_hilo("b2b_multu", n, 5, 32'd1, 32'd0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        mdif.start  = 1'b0;
        mdif.cancel = 1'b0;
        mdif.md_op  = 3'b000;
        mdif.srca   = 32'd0;
        mdif.srcb   = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_cancel();
        test_mthi_mtlo();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
